// File: rtl/plot_scheduler.sv
// ---------------------------------------------------------------------------
// plot_scheduler
//   Serialises point-plot requests from N_REQ geometry generators through one
//   shared normalized-to-screen mapper and one framebuffer write port.
//   Each granted point walks IDLE -> MAP -> CHECK -> (WRITE) -> DONE.
//
// Ports
//   ACLK, ARESET             clock (rising edge), async active-high reset
//   REQ/REQ_X/REQ_Y/REQ_COLOR per-requester plot request and packed point data
//   REQ_ACK, REQ_DROP         one-cycle completion pulse, off-screen flag
//   MAP_X/MAP_Y/MAP_ENB       coordinates and output enable to the mapper
//   MAP_XOUT/MAP_YOUT/MAP_VALID mapper result, one cycle after MAP_ENB
//   FB_WE/FB_ADDR/FB_DATA/FB_ACK framebuffer write request/acknowledge
//   BUSY                      FSM not in IDLE
//   DROP_CNT                  saturating count of dropped points
// ---------------------------------------------------------------------------
module plot_scheduler #(
    parameter int          N_REQ    = 4,
    parameter int          COLOR_W  = 8,
    parameter int          X_RESOL  = 320,
    parameter int          Y_RESOL  = 200,
    parameter int          ADDR_W   = 16,
    // Saturation ceiling for DROP_CNT
    parameter logic [15:0] DROP_SAT = 16'hFFFF
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [N_REQ-1:0]           REQ,
    input  logic [8*N_REQ-1:0]         REQ_X,
    input  logic [8*N_REQ-1:0]         REQ_Y,
    input  logic [COLOR_W*N_REQ-1:0]   REQ_COLOR,
    output logic [N_REQ-1:0]           REQ_ACK,
    output logic                       REQ_DROP,
    output logic [7:0]                 MAP_X,
    output logic [7:0]                 MAP_Y,
    output logic                       MAP_ENB,
    input  logic [15:0]                MAP_XOUT,
    input  logic [15:0]                MAP_YOUT,
    input  logic                       MAP_VALID,
    output logic                       FB_WE,
    output logic [ADDR_W-1:0]          FB_ADDR,
    output logic [COLOR_W-1:0]         FB_DATA,
    input  logic                       FB_ACK,
    output logic                       BUSY,
    output logic [15:0]                DROP_CNT
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, MAP, CHECK, WRITE, DONE} state_t;

    state_t               state_q;
    logic [GW-1:0]        last_grant_q;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        grant_d;
    logic                 grant_vld_d;
    logic [COLOR_W-1:0]   color_q;
    logic [7:0]           map_x_q, map_y_q;
    logic                 map_enb_q;
    logic [N_REQ-1:0]     req_ack_q;
    logic                 req_drop_q;
    logic                 fb_we_q;
    logic [ADDR_W-1:0]    fb_addr_q;
    logic [COLOR_W-1:0]   fb_data_q;
    logic                 busy_q;
    logic [15:0]          drop_cnt_q;

    logic                 in_range;
    logic [ADDR_W-1:0]    pix_addr;

    // Round-robin search. Walking the offsets downward lets the nearest
    // requester after last_grant_q overwrite any farther one.
    always_comb begin
        int idx;
        idx         = 0;
        grant_d     = last_grant_q;
        grant_vld_d = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last_grant_q) + i) % N_REQ;
            if (REQ[idx]) begin
                grant_d     = GW'(idx);
                grant_vld_d = 1'b1;
            end
        end
    end

    // Screen bounds and linear address; the product wraps naturally at ADDR_W.
    always_comb begin
        in_range = MAP_VALID
                && (32'(MAP_XOUT) < 32'(X_RESOL))
                && (32'(MAP_YOUT) < 32'(Y_RESOL));
        pix_addr = ADDR_W'(MAP_YOUT) * ADDR_W'(X_RESOL) + ADDR_W'(MAP_XOUT);
    end

    // NOTE: state and outputs update with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(N_REQ - 1);
            grant_q      <= '0;
            color_q      <= '0;
            map_x_q      <= '0;
            map_y_q      <= '0;
            map_enb_q    <= 1'b0;
            req_ack_q    <= '0;
            req_drop_q   <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            busy_q       <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            // Pulse-type outputs default low each cycle.
            map_enb_q  <= 1'b0;
            req_ack_q  <= '0;
            req_drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        grant_q   <= grant_d;
                        map_x_q   <= REQ_X[int'(grant_d)*8 +: 8];
                        map_y_q   <= REQ_Y[int'(grant_d)*8 +: 8];
                        color_q   <= REQ_COLOR[int'(grant_d)*COLOR_W +: COLOR_W];
                        map_enb_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= MAP;
                    end
                end
                MAP: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (in_range) begin
                        fb_addr_q <= pix_addr;
                        fb_data_q <= color_q;
                        fb_we_q   <= 1'b1;
                        state_q   <= WRITE;
                    end else begin
                        req_ack_q[grant_q] <= 1'b1;
                        req_drop_q         <= 1'b1;
                        if (drop_cnt_q != DROP_SAT) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                        state_q <= DONE;
                    end
                end
                WRITE: begin
                    if (FB_ACK) begin
                        fb_we_q            <= 1'b0;
                        req_ack_q[grant_q] <= 1'b1;
                        state_q            <= DONE;
                    end
                end
                DONE: begin
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign REQ_ACK  = req_ack_q;
    assign REQ_DROP = req_drop_q;
    assign MAP_X    = map_x_q;
    assign MAP_Y    = map_y_q;
    assign MAP_ENB  = map_enb_q;
    assign FB_WE    = fb_we_q;
    assign FB_ADDR  = fb_addr_q;
    assign FB_DATA  = fb_data_q;
    assign BUSY     = busy_q;
    assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_plot_scheduler
//   Directed bench for plot_scheduler with a behavioural mapper and a
//   scoreboard of expected completions.
// ---------------------------------------------------------------------------
module tb_plot_scheduler;

    localparam int          N_REQ = 4;
    localparam logic [15:0] SAT   = 16'd6;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [N_REQ-1:0]  REQ;
    logic [8*N_REQ-1:0] REQ_X, REQ_Y;
    logic [8*N_REQ-1:0] REQ_COLOR;
    logic [N_REQ-1:0]  REQ_ACK;
    logic              REQ_DROP;
    logic [7:0]        MAP_X, MAP_Y;
    logic              MAP_ENB;
    logic [15:0]       MAP_XOUT = '0;
    logic [15:0]       MAP_YOUT = '0;
    logic              MAP_VALID = 1'b0;
    logic              FB_WE;
    logic [15:0]       FB_ADDR;
    logic [7:0]        FB_DATA;
    logic              FB_ACK;
    logic              BUSY;
    logic [15:0]       DROP_CNT;

    plot_scheduler #(
        .N_REQ(N_REQ), .COLOR_W(8), .X_RESOL(320), .Y_RESOL(200),
        .ADDR_W(16), .DROP_SAT(SAT)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .REQ(REQ), .REQ_X(REQ_X), .REQ_Y(REQ_Y), .REQ_COLOR(REQ_COLOR),
        .REQ_ACK(REQ_ACK), .REQ_DROP(REQ_DROP),
        .MAP_X(MAP_X), .MAP_Y(MAP_Y), .MAP_ENB(MAP_ENB),
        .MAP_XOUT(MAP_XOUT), .MAP_YOUT(MAP_YOUT), .MAP_VALID(MAP_VALID),
        .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_ACK(FB_ACK),
        .BUSY(BUSY), .DROP_CNT(DROP_CNT)
    );

    always #5 ACLK = ~ACLK;

    // Behavioural mapper: returns whatever response the current step selects.
    logic [15:0] rsp_x, rsp_y;
    logic        rsp_v;
    always @(posedge ACLK) begin
        if (MAP_ENB) begin
            MAP_XOUT  <= rsp_x;
            MAP_YOUT  <= rsp_y;
            MAP_VALID <= rsp_v;
        end
    end

    typedef struct {
        int          idx;
        bit          drop;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  x;
        logic [7:0]  y;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          rr_last = N_REQ - 1;
    int          fb_delay = 0;
    bit          fb_idle_ack = 1'b0;
    logic [15:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rsp(input logic [15:0] x, input logic [15:0] y, input logic v);
        rsp_x = x;
        rsp_y = y;
        rsp_v = v;
    endtask

    task automatic set_req(input int idx, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] col);
        REQ_X[idx*8 +: 8]     = x;
        REQ_Y[idx*8 +: 8]     = y;
        REQ_COLOR[idx*8 +: 8] = col;
        REQ[idx]              = 1'b1;
    endtask

    // Expected completion for the current mapper response.
    task automatic push(input int idx, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] col);
        exp_t e;
        e.idx  = idx;
        e.x    = x;
        e.y    = y;
        e.data = col;
        e.drop = !(rsp_v && (rsp_x < 16'd320) && (rsp_y < 16'd200));
        e.addr = 16'(32'(rsp_y) * 32'd320 + 32'(rsp_x));
        sb.push_back(e);
        rr_last = idx;
    endtask

    // Advance clock, answer FB_WE, and compare each REQ_ACK against the scoreboard.
    task automatic run(input int n_acks, input bit release_on_ack);
        int          got = 0;
        int          c = 0;
        int          w = 0;
        int          c_map = -1000;
        bit          we_seen = 1'b0;
        logic [15:0] a0 = '0;
        logic [7:0]  d0 = '0;
        exp_t        e;
        while (got < n_acks && c < 200) begin
            @(posedge ACLK);
            #1;
            c++;
            if (MAP_ENB) begin
                c_map   = c;
                w       = 0;
                we_seen = 1'b0;
                if (sb.size() > 0) begin
                    check("map_x", 32'(MAP_X), 32'(sb[0].x));
                    check("map_y", 32'(MAP_Y), 32'(sb[0].y));
                end
            end
            if (FB_WE) begin
                if (!we_seen) begin
                    if (sb.size() > 0) begin
                        check("fb_we_on_drop", 32'(sb[0].drop), 32'd0);
                        check("fb_addr", 32'(FB_ADDR), 32'(sb[0].addr));
                        check("fb_data", 32'(FB_DATA), 32'(sb[0].data));
                    end
                    a0      = FB_ADDR;
                    d0      = FB_DATA;
                    we_seen = 1'b1;
                end else begin
                    check("fb_addr_stable", 32'(FB_ADDR), 32'(a0));
                    check("fb_data_stable", 32'(FB_DATA), 32'(d0));
                end
                check("busy_in_write", 32'(BUSY), 32'd1);
                FB_ACK = (w == fb_delay);
                w++;
            end else begin
                FB_ACK = fb_idle_ack;
            end
            if (REQ_ACK != '0) begin
                if (sb.size() == 0) begin
                    check("spurious_ack", 32'(REQ_ACK), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_vec", 32'(REQ_ACK), 32'd1 << e.idx);
                    check("req_drop", 32'(REQ_DROP), 32'(e.drop));
                    check("wrote", 32'(we_seen), 32'(!e.drop));
                    check("latency", 32'(c - c_map), e.drop ? 32'd2 : 32'(3 + fb_delay));
                    if (e.drop && exp_cnt != SAT) exp_cnt = exp_cnt + 16'd1;
                    check("drop_cnt", 32'(DROP_CNT), 32'(exp_cnt));
                    if (release_on_ack) REQ[e.idx] = 1'b0;
                end
                got++;
            end
        end
        FB_ACK = 1'b0;
        check("ack_timeout", 32'(got), 32'(n_acks));
    endtask

    initial begin
        ARESET    = 1'b1;
        REQ       = '0;
        REQ_X     = '0;
        REQ_Y     = '0;
        REQ_COLOR = '0;
        FB_ACK    = 1'b0;
        set_rsp(16'd0, 16'd0, 1'b0);
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_ack",   32'(REQ_ACK),  32'd0);
        check("rst_drop",  32'(REQ_DROP), 32'd0);
        check("rst_mapx",  32'(MAP_X),    32'd0);
        check("rst_mapy",  32'(MAP_Y),    32'd0);
        check("rst_enb",   32'(MAP_ENB),  32'd0);
        check("rst_we",    32'(FB_WE),    32'd0);
        check("rst_addr",  32'(FB_ADDR),  32'd0);
        check("rst_data",  32'(FB_DATA),  32'd0);
        check("rst_busy",  32'(BUSY),     32'd0);
        check("rst_cnt",   32'(DROP_CNT), 32'd0);
        ARESET = 1'b0;

        // Single request from requester 0, immediate FB_ACK -> address 31838.
        set_rsp(16'd158, 16'd99, 1'b1);
        set_req(0, 8'd0, 8'd0, 8'h5A);
        push(0, 8'd0, 8'd0, 8'h5A);
        run(1, 1'b1);
        check("busy_after", 32'(BUSY), 32'd1);   // DONE cycle still busy
        @(posedge ACLK); #1;
        check("idle_busy", 32'(BUSY), 32'd0);

        // All four requesting continuously; FB_ACK held high also outside WRITE.
        set_rsp(16'd10, 16'd20, 1'b1);
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'(i + 1), 8'(2 * i + 1), 8'(8'h10 + i));
        for (int k = 0; k < 8; k++) begin
            int nx;
            nx = (rr_last + 1) % N_REQ;
            push(nx, 8'(nx + 1), 8'(2 * nx + 1), 8'(8'h10 + nx));
        end
        fb_idle_ack = 1'b1;
        run(8, 1'b0);
        REQ = '0;
        fb_idle_ack = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;

        // FB_ACK withheld for 10 cycles.
        fb_delay = 10;
        set_rsp(16'd5, 16'd7, 1'b1);
        set_req(2, 8'd1, 8'd2, 8'hC3);
        push(2, 8'd1, 8'd2, 8'hC3);
        run(1, 1'b1);
        fb_delay = 0;

        // Corner pixels.
        set_rsp(16'd319, 16'd199, 1'b1);
        set_req(1, 8'hFF, 8'hFF, 8'h77);
        push(1, 8'hFF, 8'hFF, 8'h77);
        run(1, 1'b1);
        set_rsp(16'd0, 16'd0, 1'b1);
        set_req(3, 8'h80, 8'h40, 8'h11);
        push(3, 8'h80, 8'h40, 8'h11);
        run(1, 1'b1);

        // Off-screen points: invalid, X at limit, Y at limit, then saturation.
        set_rsp(16'd10, 16'd10, 1'b0);
        set_req(3, 8'd3, 8'd3, 8'h33);
        push(3, 8'd3, 8'd3, 8'h33);
        run(1, 1'b1);
        set_rsp(16'd320, 16'd0, 1'b1);
        set_req(1, 8'd4, 8'd4, 8'h44);
        push(1, 8'd4, 8'd4, 8'h44);
        run(1, 1'b1);
        set_rsp(16'd0, 16'd200, 1'b1);
        set_req(0, 8'd5, 8'd5, 8'h55);
        push(0, 8'd5, 8'd5, 8'h55);
        run(1, 1'b1);
        set_rsp(16'd0, 16'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            set_req(k % N_REQ, 8'(k), 8'(k), 8'(k));
            push(k % N_REQ, 8'(k), 8'(k), 8'(k));
            run(1, 1'b1);
        end
        check("drop_sat", 32'(DROP_CNT), 32'(SAT));

        // Reset during WRITE with requester 2 pending.
        set_rsp(16'd50, 16'd60, 1'b1);
        set_req(1, 8'd9, 8'd9, 8'h99);
        begin
            int c;
            c = 0;
            while (!FB_WE && c < 20) begin
                @(posedge ACLK);
                #1;
                c++;
            end
            check("abort_reach_write", 32'(FB_WE), 32'd1);
        end
        set_req(2, 8'd7, 8'd8, 8'hA5);
        #2;
        ARESET = 1'b1;
        #1;
        check("abort_we",   32'(FB_WE),    32'd0);
        check("abort_busy", 32'(BUSY),     32'd0);
        check("abort_ack",  32'(REQ_ACK),  32'd0);
        check("abort_cnt",  32'(DROP_CNT), 32'd0);
        @(posedge ACLK);
        #1;
        ARESET  = 1'b0;
        REQ[1]  = 1'b0;
        exp_cnt = '0;
        rr_last = N_REQ - 1;
        set_rsp(16'd1, 16'd2, 1'b1);
        push(2, 8'd7, 8'd8, 8'hA5);
        run(1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
